// File: rtl/tqvp_bus_initiator.sv
// Host-side initiator for the TinyQV peripheral bus: turns one command at a time
// into write/read strobes and returns the result on a response channel.
module tqvp_bus_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_size,
  input  logic [5:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [5:0]  p_address,
  output logic [31:0] p_data_in,
  output logic [1:0]  p_data_write_n,
  output logic [1:0]  p_data_read_n,
  input  logic [31:0] p_data_out,
  input  logic        p_data_ready
);

  // Handshakes: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // a response transfers on a rising edge where rsp_valid && rsp_ready, and
  // rsp_rdata/rsp_err stay stable while rsp_valid is high and not yet taken.

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0] STROBE_IDLE = 2'b11;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  logic [1:0]    state;
  logic [1:0]    size_q;
  logic [CW-1:0] count;

  assign cmd_ready = (state == ST_IDLE);

  function automatic logic [31:0] mask_data(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   mask_data = {24'b0, data[7:0]};
      2'b01:   mask_data = {16'b0, data[15:0]};
      default: mask_data = data;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      size_q         <= 2'b00;
      count          <= '0;
      rsp_valid      <= 1'b0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= 32'b0;
      p_address      <= 6'b0;
      p_data_in      <= 32'b0;
      p_data_write_n <= STROBE_IDLE;
      p_data_read_n  <= STROBE_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            size_q <= cmd_size;
            if (cmd_size == SIZE_ILLEGAL) begin
              // Illegal size never touches the bus; answer with an error directly.
              rsp_err   <= 1'b1;
              rsp_rdata <= 32'b0;
              state     <= ST_RESP;
            end else begin
              p_address <= cmd_addr;
              if (cmd_write) begin
                p_data_in      <= cmd_wdata;
                p_data_write_n <= cmd_size;
                state          <= ST_WRITE;
              end else begin
                p_data_read_n <= cmd_size;
                count         <= '0;
                state         <= ST_READ;
              end
            end
          end
        end
        ST_WRITE: begin
          p_data_write_n <= STROBE_IDLE;
          rsp_err        <= 1'b0;
          rsp_rdata      <= 32'b0;
          state          <= ST_RESP;
        end
        ST_READ: begin
          if (p_data_ready) begin
            rsp_rdata     <= mask_data(size_q, p_data_out);
            rsp_err       <= 1'b0;
            p_data_read_n <= STROBE_IDLE;
            state         <= ST_RESP;
          end else if (count == CNT_LAST) begin
            rsp_rdata     <= 32'b0;
            rsp_err       <= 1'b1;
            p_data_read_n <= STROBE_IDLE;
            state         <= ST_RESP;
          end else begin
            count <= count + 1'b1;
          end
        end
        ST_RESP: begin
          // First RESP cycle raises rsp_valid; it then holds until consumed.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
